// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU definitions: exception codes, CP0 indices, exception vector, controller states
package cpu_defs;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam int CP0_BADVADDR = 8;
    localparam int CP0_STATUS   = 12;
    localparam int CP0_CAUSE    = 13;
    localparam int CP0_EPC      = 14;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    // Only address errors carry a faulting address worth writing to BadVAddr.
    function automatic logic sets_badvaddr(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// rtl/exception_ctrl_if.sv - MEM-stage / CP0 / fetch-redirect signal bundle for exception_ctrl
// Ports: mem_* (MEM-stage instruction), hw_int, CP0 read data in; CP0 write enables/data,
// flush, busy and the redirect_valid/redirect_pc/redirect_ready handshake.
// slave = exception controller side, master = pipeline / CP0 / fetch side.
interface exception_ctrl_if #(
    parameter int WIDTH = 32
);
    logic              mem_valid;
    logic [WIDTH-1:0]  mem_pc;
    logic              mem_in_delay;
    logic [5:0]        mem_exc;
    logic              mem_is_store;
    logic [WIDTH-1:0]  mem_addr;
    logic              mem_eret;
    logic [5:0]        hw_int;
    logic [WIDTH-1:0]  Status_data;
    logic [WIDTH-1:0]  cause_data;
    logic [WIDTH-1:0]  EPC_data;
    logic [WIDTH-1:0]  we;
    logic [WIDTH-1:0]  epc;
    logic [WIDTH-1:0]  BADADDR;
    logic [4:0]        Exception_code;
    logic              Branch_delay;
    logic [7:0]        interrupt_enable;
    logic              EXL;
    logic              IE;
    logic              flush;
    logic              busy;
    logic              redirect_valid;
    logic [WIDTH-1:0]  redirect_pc;
    logic              redirect_ready;

    modport slave (
        input  mem_valid, mem_pc, mem_in_delay, mem_exc, mem_is_store, mem_addr, mem_eret,
        input  hw_int, Status_data, cause_data, EPC_data, redirect_ready,
        output we, epc, BADADDR, Exception_code, Branch_delay, interrupt_enable, EXL, IE,
        output flush, busy, redirect_valid, redirect_pc
    );

    modport master (
        output mem_valid, mem_pc, mem_in_delay, mem_exc, mem_is_store, mem_addr, mem_eret,
        output hw_int, Status_data, cause_data, EPC_data, redirect_ready,
        input  we, epc, BADADDR, Exception_code, Branch_delay, interrupt_enable, EXL, IE,
        input  flush, busy, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - fixed-priority exception cause encoder
// Ports: int_req, mem_exc {fetch_adel, ri, ov, sys, bp, data_ade}, mem_is_store in;
// hit and 5-bit ExcCode out.
module exc_prio_enc
    import cpu_defs::*;
(
    input  logic       int_req,
    input  logic [5:0] mem_exc,
    input  logic       mem_is_store,
    output logic       hit,
    output logic [4:0] code
);

    always_comb begin
        hit  = 1'b1;
        code = EXC_INT;
        if (int_req)         code = EXC_INT;
        else if (mem_exc[5]) code = EXC_ADEL;
        else if (mem_exc[4]) code = EXC_RI;
        else if (mem_exc[3]) code = EXC_OV;
        else if (mem_exc[2]) code = EXC_SYS;
        else if (mem_exc[1]) code = EXC_BP;
        else if (mem_exc[0]) code = mem_is_store ? EXC_ADES : EXC_ADEL;
        else                 hit  = 1'b0;
    end

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - commit-point exception/interrupt controller feeding CP0 and fetch redirect
// Ports: clk, rst (async active-low), bus (exception_ctrl_if.slave) carrying the MEM-stage
// instruction, interrupt lines, CP0 read/write signals, flush/busy and the redirect handshake.
module exception_ctrl #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(cpu_defs::EXC_VECTOR)
) (
    input  logic             clk,
    input  logic             rst,
    exception_ctrl_if.slave  bus
);
    import cpu_defs::*;

    logic [5:0]       int_meta_q, int_sync_q;
    logic             int_req, exc_hit, take_eret;
    logic [4:0]       exc_code;

    state_e           state_q, state_d;
    logic [4:0]       code_q, code_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] badaddr_q, badaddr_d;
    logic             bd_q, bd_d;
    logic             is_eret_q, is_eret_d;
    logic             badv_q, badv_d;
    logic             flush;
    logic             in_write, in_redirect;
    logic [WIDTH-1:0] we;

    logic unused_bits;
    assign unused_bits = ^{bus.cause_data[WIDTH-1:10], bus.cause_data[7:0],
                           bus.Status_data[WIDTH-1:16], bus.Status_data[7:2]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_meta_q <= '0;
            int_sync_q <= '0;
        end else begin
            int_meta_q <= bus.hw_int;
            int_sync_q <= int_meta_q;
        end
    end

    // IE set, EXL clear, and any pending line (6 hardware + 2 software) unmasked by IM.
    assign int_req = bus.Status_data[0] & ~bus.Status_data[1]
                   & |({int_sync_q, bus.cause_data[9:8]} & bus.Status_data[15:8]);

    exc_prio_enc u_prio (
        .int_req      (int_req & bus.mem_valid),
        .mem_exc      (bus.mem_exc & {6{bus.mem_valid}}),
        .mem_is_store (bus.mem_is_store),
        .hit          (exc_hit),
        .code         (exc_code)
    );

    // Any exception on the same instruction pre-empts ERET.
    assign take_eret = bus.mem_valid & bus.mem_eret & ~exc_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            epc_q     <= '0;
            badaddr_q <= '0;
            bd_q      <= 1'b0;
            is_eret_q <= 1'b0;
            badv_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            epc_q     <= epc_d;
            badaddr_q <= badaddr_d;
            bd_q      <= bd_d;
            is_eret_q <= is_eret_d;
            badv_q    <= badv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        epc_d     = epc_q;
        badaddr_d = badaddr_q;
        bd_d      = bd_q;
        is_eret_d = is_eret_q;
        badv_d    = badv_q;
        flush     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (exc_hit) begin
                    flush     = 1'b1;
                    state_d   = ST_WRITE;
                    code_d    = exc_code;
                    epc_d     = bus.mem_in_delay ? bus.mem_pc - WIDTH'(4) : bus.mem_pc;
                    badaddr_d = bus.mem_exc[5] ? bus.mem_pc : bus.mem_addr;
                    bd_d      = bus.mem_in_delay;
                    is_eret_d = 1'b0;
                    badv_d    = sets_badvaddr(exc_code) && !int_req;
                end else if (take_eret) begin
                    flush     = 1'b1;
                    state_d   = ST_WRITE;
                    code_d    = '0;
                    epc_d     = bus.mem_pc;
                    badaddr_d = bus.mem_addr;
                    bd_d      = 1'b0;
                    is_eret_d = 1'b1;
                    badv_d    = 1'b0;
                end
            end
            ST_WRITE: begin
                flush   = 1'b1;
                state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                flush = 1'b1;
                if (bus.redirect_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_write    = (state_q == ST_WRITE);
    assign in_redirect = (state_q == ST_REDIRECT);

    // Enables are confined to the single WRITE cycle so MTC0 is never overridden elsewhere.
    always_comb begin
        we = '0;
        if (in_write) begin
            if (is_eret_q) begin
                we[CP0_STATUS] = 1'b1;
            end else begin
                we[CP0_STATUS]   = 1'b1;
                we[CP0_CAUSE]    = 1'b1;
                we[CP0_EPC]      = 1'b1;
                we[CP0_BADVADDR] = badv_q;
            end
        end
    end

    assign bus.we               = we;
    assign bus.epc              = in_write ? epc_q : '0;
    assign bus.BADADDR          = in_write ? badaddr_q : '0;
    assign bus.Exception_code   = in_write ? code_q : '0;
    assign bus.Branch_delay     = in_write & bd_q;
    assign bus.EXL              = in_write & ~is_eret_q;
    assign bus.interrupt_enable = bus.Status_data[15:8];
    assign bus.IE               = bus.Status_data[0];
    assign bus.flush            = flush;
    assign bus.busy             = (state_q != ST_IDLE);
    assign bus.redirect_valid   = in_redirect;
    assign bus.redirect_pc      = in_redirect ? (is_eret_q ? bus.EPC_data : EXC_VECTOR) : '0;

endmodule
